gshare_btb_predictor: RTL and testbench

//  Parametrised gshare direction predictor with tagged BTB for the 5-stage pipelined core.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_pht.sv | 30 +++
 rtl/gshare_btb_predictor.sv | 72 +++++++
 tb/tb_gshare_btb_predictor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared BTB entry type, index/tag helpers and counter constants for the gshare predictor
package bp_pkg;
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic        is_cond;
  } btb_entry_t;
  function automatic logic [31:0] btb_idx(input logic [31:0] pc, input int idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction
  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_bits);
    return pc >> (2 + idx_bits);
  endfunction
  function automatic logic [31:0] pht_idx(input logic [31:0] pc, input logic [31:0] ghr, input int bits);
    return ((pc >> 2) ^ ghr) & ((32'd1 << bits) - 32'd1);
  endfunction
  function automatic logic [3:0] ctr_init(input int cb);
    return 4'((32'd1 << (cb - 1)) - 32'd1);
  endfunction
  function automatic logic [3:0] ctr_max(input int cb);
    return 4'((32'd1 << cb) - 32'd1);
  endfunction
  function automatic logic [3:0] ctr_next(input logic [3:0] c, input logic up, input int cb);
    return up ? ((c == ctr_max(cb)) ? c : c + 4'd1) : ((c == 4'd0) ? c : c - 4'd1);
  endfunction
endpackage

// File: rtl/bp_pht.sv
// bp_pht: pattern history table of saturating counters with one read and one training port
module bp_pht
  import bp_pkg::*;
#(
  parameter int GHR_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [GHR_BITS-1:0] i_rd_idx,
  output logic [CTR_BITS-1:0] o_rd_ctr,
  input  logic                i_wr_en,
  input  logic [GHR_BITS-1:0] i_wr_idx,
  input  logic                i_wr_taken
);
  localparam int N = 2 ** GHR_BITS;
  localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(ctr_init(CTR_BITS));
  logic [CTR_BITS-1:0] r_ctr [N];
  logic [CTR_BITS-1:0] w_next;
  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_next = CTR_BITS'(ctr_next(4'(r_ctr[i_wr_idx]), i_wr_taken, CTR_BITS));
  // clear every counter to weakly-not-taken on reset, otherwise train the addressed counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_ctr[i] <= INIT;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_next;
    end
  end
endmodule

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: same-cycle gshare direction + tagged BTB target prediction with GHR repair
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int GHR_BITS    = 8,
  parameter int BTB_ENTRIES = 32,
  parameter int CTR_BITS    = 2,
  parameter int SPEC_GHR    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  input  logic                pred_fire,
  output logic                predict_taken,
  output logic [31:0]         next_pc,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic                update_is_cond,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                update_mispredict
);
  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  btb_entry_t          r_btb [BTB_ENTRIES];
  btb_entry_t          w_ent;
  logic [GHR_BITS-1:0] r_ghr, w_ghr_nxt, w_pht_ridx, w_pht_widx;
  logic [IDX_BITS-1:0] w_idx, w_uidx;
  logic [CTR_BITS-1:0] w_ctr;
  logic                w_hit, w_spec_shift, w_repair;
  assign w_idx      = IDX_BITS'(btb_idx(pc, IDX_BITS));
  assign w_uidx     = IDX_BITS'(btb_idx(update_pc, IDX_BITS));
  assign w_pht_ridx = GHR_BITS'(pht_idx(pc, 32'(r_ghr), GHR_BITS));
  assign w_pht_widx = GHR_BITS'(pht_idx(update_pc, 32'(update_ghr), GHR_BITS));
  assign w_ent      = r_btb[w_idx];
  assign w_hit      = w_ent.valid && (w_ent.tag == 30'(btb_tag(pc, IDX_BITS)));
  assign predict_taken = w_hit && (!w_ent.is_cond || w_ctr[CTR_BITS-1]);
  assign next_pc    = predict_taken ? w_ent.target : pc + 32'd4;
  assign pred_ghr   = r_ghr;
  assign w_spec_shift = pred_fire && w_hit && w_ent.is_cond;
  assign w_repair     = update_valid && update_mispredict;
  assign w_ghr_nxt = (SPEC_GHR != 0)
    ? (w_repair ? (update_is_cond ? {update_ghr[GHR_BITS-2:0], update_taken} : update_ghr)
                : (w_spec_shift ? {r_ghr[GHR_BITS-2:0], predict_taken} : r_ghr))
    : ((update_valid && update_is_cond) ? {r_ghr[GHR_BITS-2:0], update_taken} : r_ghr);
  bp_pht #(
    .GHR_BITS(GHR_BITS),
    .CTR_BITS(CTR_BITS)
  ) u_pht (
    .clk       (clk),
    .reset     (reset),
    .i_rd_idx  (w_pht_ridx),
    .o_rd_ctr  (w_ctr),
    .i_wr_en   (update_valid && update_is_cond),
    .i_wr_idx  (w_pht_widx),
    .i_wr_taken(update_taken)
  );
  // allocate or overwrite the BTB entry of every resolved taken control-flow instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb[i] <= '0;
    end else if (update_valid && update_taken) begin
      r_btb[w_uidx] <= '{valid: 1'b1, tag: 30'(btb_tag(update_pc, IDX_BITS)),
                         target: update_target, is_cond: update_is_cond};
    end
  end
  // global history: speculative shift or repair, or retire-time shift
  always_ff @(posedge clk) begin
    r_ghr <= reset ? '0 : w_ghr_nxt;
  end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb_gshare_btb_predictor: directed and random checks of both GHR modes against a behavioural model
module tb_gshare_btb_predictor;
  localparam int N = 32;
  logic        clk = 1'b0;
  logic        reset, pred_fire, update_valid, update_is_cond, update_taken, update_mispredict;
  logic [31:0] pc, update_pc, update_target;
  logic [7:0]  update_ghr;
  logic        pt1, pt0;
  logic [31:0] np1, np0;
  logic [7:0]  pg1, pg0;
  bit          m_valid [N];
  bit          m_cond  [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [256];
  logic [31:0] m_g1, m_g0;
  int          n_tests = 0;
  int          n_fail  = 0;
  always #5 clk = ~clk;
  gshare_btb_predictor #(.GHR_BITS(8), .BTB_ENTRIES(32), .CTR_BITS(2), .SPEC_GHR(1)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pred_fire(pred_fire),
    .predict_taken(pt1), .next_pc(np1), .pred_ghr(pg1),
    .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
    .update_taken(update_taken), .update_target(update_target), .update_ghr(update_ghr),
    .update_mispredict(update_mispredict));
  gshare_btb_predictor #(.GHR_BITS(8), .BTB_ENTRIES(32), .CTR_BITS(2), .SPEC_GHR(0)) dut0 (
    .clk(clk), .reset(reset), .pc(pc), .pred_fire(pred_fire),
    .predict_taken(pt0), .next_pc(np0), .pred_ghr(pg0),
    .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
    .update_taken(update_taken), .update_target(update_target), .update_ghr(update_ghr),
    .update_mispredict(update_mispredict));
  function automatic void mpred(input logic [31:0] p, input logic [31:0] g, output bit tk,
                                output logic [31:0] np, output bit hit, output bit cond);
    int i;
    int k;
    i = int'((p >> 2) % N);
    k = int'(((p >> 2) ^ g) % 256);
    hit  = m_valid[i] && ((m_pc[i] >> 7) == (p >> 7));
    cond = m_cond[i];
    tk   = hit && (!cond || m_ctr[k] >= 2);
    np   = tk ? m_tgt[i] : p + 32'd4;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    bit tk, hit, cond;
    logic [31:0] np;
    mpred(pc, m_g1, tk, np, hit, cond);
    chk({tag, "_taken1"}, 32'(pt1), 32'(tk));
    chk({tag, "_npc1"}, np1, np);
    chk({tag, "_ghr1"}, 32'(pg1), m_g1);
    mpred(pc, m_g0, tk, np, hit, cond);
    chk({tag, "_taken0"}, 32'(pt0), 32'(tk));
    chk({tag, "_npc0"}, np0, np);
    chk({tag, "_ghr0"}, 32'(pg0), m_g0);
  endtask
  task automatic model_clock;
    bit tk, hit, cond;
    logic [31:0] np;
    int i, k;
    if (reset) begin
      for (int j = 0; j < N; j++) begin
        m_valid[j] = 0; m_cond[j] = 0; m_pc[j] = 0; m_tgt[j] = 0;
      end
      for (int j = 0; j < 256; j++) m_ctr[j] = 1;
      m_g1 = 0;
      m_g0 = 0;
    end else begin
      mpred(pc, m_g1, tk, np, hit, cond);
      if (update_valid && update_is_cond) begin
        k = int'(((update_pc >> 2) ^ 32'(update_ghr)) % 256);
        m_ctr[k] = update_taken ? (m_ctr[k] == 3 ? 3 : m_ctr[k] + 1) : (m_ctr[k] == 0 ? 0 : m_ctr[k] - 1);
      end
      if (update_valid && update_taken) begin
        i = int'((update_pc >> 2) % N);
        m_valid[i] = 1; m_pc[i] = update_pc; m_tgt[i] = update_target; m_cond[i] = update_is_cond;
      end
      if (update_valid && update_mispredict)
        m_g1 = update_is_cond ? (((32'(update_ghr) << 1) | 32'(update_taken)) & 32'hFF) : 32'(update_ghr);
      else if (pred_fire && hit && cond)
        m_g1 = ((m_g1 << 1) | 32'(tk)) & 32'hFF;
      if (update_valid && update_is_cond)
        m_g0 = ((m_g0 << 1) | 32'(update_taken)) & 32'hFF;
    end
  endtask
  task automatic tick;
    @(posedge clk);
    model_clock();
    #1;
  endtask
  task automatic idle;
    pred_fire = 0; update_valid = 0; update_pc = 0; update_is_cond = 0;
    update_taken = 0; update_target = 0; update_ghr = 0; update_mispredict = 0;
  endtask
  task automatic upd(input logic [31:0] p, input logic c, input logic t, input logic [31:0] tg,
                     input logic [7:0] g, input logic m);
    update_valid = 1; update_pc = p; update_is_cond = c; update_taken = t;
    update_target = tg; update_ghr = g; update_mispredict = m;
  endtask
  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    p = (32'(($urandom_range(0, 63))) << 2) + ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h0);
    return ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : p;
  endfunction
  initial begin
    reset = 1; idle(); pc = 32'h40;
    tick();
    reset = 0; #1;
    chk("rst_taken", 32'(pt1), 32'd0);
    chk("rst_npc", np1, 32'h44);
    chk("rst_ghr", 32'(pg1), 32'd0);
    check_all("rst");
    upd(32'h40, 0, 1, 32'h100, 8'h00, 0);
    tick();
    idle(); pc = 32'h40; #1;
    chk("jal_taken", 32'(pt1), 32'd1);
    chk("jal_npc1", np1, 32'h100);
    chk("jal_npc0", np0, 32'h100);
    pc = 32'hC0; #1;
    chk("alias_taken", 32'(pt1), 32'd0);
    chk("alias_npc", np1, 32'hC4);
    check_all("alias");
    for (int r = 0; r < 2; r++) begin
      upd(32'h80, 1, 1, 32'h20, 8'h00, 0);
      tick();
    end
    idle(); pc = 32'h80; #1;
    chk("ctr3_npc", np1, 32'h20);
    check_all("ctr3");
    upd(32'h80, 1, 1, 32'h20, 8'h00, 0); tick();
    upd(32'h80, 1, 0, 32'h20, 8'h00, 0); tick();
    idle(); pc = 32'h80; #1;
    chk("hold3_taken", 32'(pt1), 32'd1);
    for (int r = 0; r < 2; r++) begin
      upd(32'h80, 1, 0, 32'h20, 8'h00, 0);
      tick();
    end
    idle(); pc = 32'h80; #1;
    chk("ctr0_taken", 32'(pt1), 32'd0);
    chk("ctr0_npc", np1, 32'h84);
    upd(32'h80, 1, 0, 32'h20, 8'h00, 0); tick();
    upd(32'h80, 1, 1, 32'h20, 8'h00, 0); tick();
    idle(); pc = 32'h80; #1;
    chk("hold0_taken", 32'(pt1), 32'd0);
    check_all("hold0");
    for (int r = 0; r < 2; r++) begin
      upd(32'h80, 1, 1, 32'h20, 8'h05, 0);
      tick();
    end
    upd(32'h304, 1, 1, 32'h400, 8'h02, 1); tick();
    idle(); pc = 32'h80; pred_fire = 1; #1;
    chk("spec_ghr_pre", 32'(pg1), 32'h05);
    chk("spec_taken", 32'(pt1), 32'd1);
    chk("spec_npc", np1, 32'h20);
    tick();
    idle(); #1;
    chk("spec_ghr_shift", 32'(pg1), 32'h0B);
    check_all("spec");
    upd(32'h304, 1, 1, 32'h400, 8'h02, 1); tick();
    idle(); #1;
    chk("repair_ghr_pre", 32'(pg1), 32'h05);
    pc = 32'h80; pred_fire = 1;
    upd(32'h500, 1, 0, 32'h0, 8'h30, 1); #1;
    check_all("repair_pre");
    tick();
    idle(); #1;
    chk("repair_ghr", 32'(pg1), 32'h60);
    check_all("repair");
    reset = 1; upd(32'h600, 0, 1, 32'h700, 8'h00, 0);
    tick();
    reset = 0; idle(); pc = 32'h600; #1;
    chk("rstdom_taken", 32'(pt1), 32'd0);
    chk("rstdom_npc", np1, 32'h604);
    chk("rstdom_ghr1", 32'(pg1), 32'd0);
    chk("rstdom_ghr0", 32'(pg0), 32'd0);
    pc = 32'hFFFFFFFC; #1;
    chk("wrap_npc1", np1, 32'h0);
    chk("wrap_npc0", np0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      pc = rnd_pc();
      pred_fire = $urandom_range(0, 1) != 0;
      update_valid = $urandom_range(0, 2) != 0;
      update_pc = rnd_pc();
      update_is_cond = $urandom_range(0, 3) != 0;
      update_taken = $urandom_range(0, 1) != 0;
      update_target = $urandom & 32'hFFFFFFFC;
      update_ghr = ($urandom_range(0, 1) != 0) ? m_g1[7:0] : 8'($urandom);
      update_mispredict = $urandom_range(0, 3) == 0;
      #1;
      check_all("rnd");
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
